// File: rtl/btn_debouncer_multi.sv
// rtl/btn_debouncer_multi.sv - multi-channel button debouncer with press/release pulses and auto-repeat
module btn_debouncer_multi #(
  parameter int                NUM_CH       = 4,
  parameter int                SAMPLES      = 3,
  parameter logic [NUM_CH-1:0] REPEAT_MASK  = '0,
  parameter int                REPEAT_DELAY = 16,
  parameter int                REPEAT_RATE  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic [NUM_CH-1:0] btn,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] press,
  output logic [NUM_CH-1:0] release_pulse
);

  // The repeat counter only ever needs to reach the larger of the two intervals.
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW      = $clog2(REP_MAX + 1);

  typedef enum logic {
    PH_DELAY = 1'b0,
    PH_RATE  = 1'b1
  } phase_t;

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      localparam bit REP_EN = REPEAT_MASK[i];

      logic [SAMPLES-2:0] hist_q, hist_d;
      logic               level_q, level_d;
      logic               press_q, press_d;
      logic               rel_q, rel_d;
      logic [CW-1:0]      cnt_q, cnt_d;
      logic [CW-1:0]      cnt_inc;
      phase_t             phase_q, phase_d;
      logic [SAMPLES-1:0] win;

      // Window is the stored history plus the sample being taken this tick.
      assign win     = {hist_q, btn[i]};
      assign cnt_inc = cnt_q + CW'(1);

      // Channel state register; reset clears everything without emitting a release.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          hist_q  <= '0;
          level_q <= 1'b0;
          press_q <= 1'b0;
          rel_q   <= 1'b0;
          cnt_q   <= '0;
          phase_q <= PH_DELAY;
        end else begin
          hist_q  <= hist_d;
          level_q <= level_d;
          press_q <= press_d;
          rel_q   <= rel_d;
          cnt_q   <= cnt_d;
          phase_q <= phase_d;
        end
      end

      // Qualify level changes on a full window; otherwise advance the auto-repeat timer.
      always_comb begin
        hist_d  = hist_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (sample_en) begin
          hist_d = win[SAMPLES-2:0];
          if ((&win) && !level_q) begin
            level_d = 1'b1;
            press_d = 1'b1;
            cnt_d   = '0;
            phase_d = PH_DELAY;
          end else if (!(|win) && level_q) begin
            level_d = 1'b0;
            rel_d   = 1'b1;
            cnt_d   = '0;
            phase_d = PH_DELAY;
          end else if (REP_EN && level_q) begin
            cnt_d = cnt_inc;
            case (phase_q)
              PH_DELAY: begin
                if (cnt_inc == CW'(REPEAT_DELAY)) begin
                  press_d = 1'b1;
                  cnt_d   = '0;
                  phase_d = PH_RATE;
                end
              end
              PH_RATE: begin
                if (cnt_inc == CW'(REPEAT_RATE)) begin
                  press_d = 1'b1;
                  cnt_d   = '0;
                end
              end
              default: phase_d = PH_DELAY;
            endcase
          end
        end
      end

      assign level[i]         = level_q;
      assign press[i]         = press_q;
      assign release_pulse[i] = rel_q;
    end
  endgenerate

endmodule
